// File: rtl/operand_entry_ctrl_pkg.sv
// Shared types and constants for the operand entry controller.
// FSM state encodings, operand index values, default timing params.
package operand_entry_ctrl_pkg;

  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_COMPUTE_CYCLES  = 5;

  localparam logic [1:0] OP_A = 2'd0;
  localparam logic [1:0] OP_B = 2'd1;
  localparam logic [1:0] OP_C = 2'd2;
  localparam logic [1:0] OP_X = 2'd3;

  typedef enum logic [2:0] {
    ST_ENTRY,
    ST_HELD,
    ST_COMPUTE,
    ST_DONE,
    ST_REARM
  } state_e;

endpackage

// File: rtl/operand_entry_ctrl_key_debounce.sv
// key_debounce: 2-flop sync of ~key_n plus stable-count debounce.
// Ports: clk, resetn, key_n (raw, active-low), key_level (clean, high=pressed).
module key_debounce
  import operand_entry_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic resetn,
  input  logic key_n,
  output logic key_level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          level_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Level flips on the Nth consecutive disagreeing sample;
  // any agreeing sample restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= ~key_n;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign key_level = level_q;

endmodule

// File: rtl/operand_entry_ctrl.sv
// Operand entry controller: sequences A,B,C,X entry for the evaluator.
// Ports: clk, resetn, key_n, sw[7:0] in; go, data_out, operand_idx, busy, result_valid out.
module operand_entry_ctrl
  import operand_entry_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int COMPUTE_CYCLES  = DEF_COMPUTE_CYCLES
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       key_n,
  input  logic [7:0] sw,
  output logic       go,
  output logic [7:0] data_out,
  output logic [1:0] operand_idx,
  output logic       busy,
  output logic       result_valid
);

  localparam int CW = $clog2(COMPUTE_CYCLES + 2);

  logic          key_lvl;
  logic [7:0]    sw_s1_q;
  logic [7:0]    sw_s2_q;

  state_e        state_q, state_d;
  logic          go_q, go_d;
  logic          busy_q, busy_d;
  logic          rv_q, rv_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key (
    .clk      (clk),
    .resetn   (resetn),
    .key_n    (key_n),
    .key_level(key_lvl)
  );

  always_comb begin
    state_d = state_q;
    go_d    = go_q;
    busy_d  = busy_q;
    rv_d    = 1'b0;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_ENTRY: begin
        if (key_lvl) begin
          go_d    = 1'b1;
          state_d = ST_HELD;
        end
      end
      ST_HELD: begin
        if (!key_lvl) begin
          go_d = 1'b0;
          if (idx_q == OP_X) begin
            idx_d   = OP_A;
            busy_d  = 1'b1;
            cnt_d   = '0;
            state_d = ST_COMPUTE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = ST_ENTRY;
          end
        end
      end
      // busy spans the go-fall edge plus COMPUTE_CYCLES more
      ST_COMPUTE: begin
        if (cnt_q == CW'(COMPUTE_CYCLES)) begin
          busy_d  = 1'b0;
          rv_d    = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // a key still held here must be released before the next go
      ST_DONE: begin
        state_d = key_lvl ? ST_REARM : ST_ENTRY;
      end
      ST_REARM: begin
        if (!key_lvl) state_d = ST_ENTRY;
      end
      default: state_d = ST_ENTRY;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
      state_q <= ST_ENTRY;
      go_q    <= 1'b0;
      busy_q  <= 1'b0;
      rv_q    <= 1'b0;
      idx_q   <= OP_A;
      cnt_q   <= '0;
    end else begin
      sw_s1_q <= sw;
      sw_s2_q <= sw_s1_q;
      state_q <= state_d;
      go_q    <= go_d;
      busy_q  <= busy_d;
      rv_q    <= rv_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign go           = go_q;
  assign busy         = busy_q;
  assign result_valid = rv_q;
  assign operand_idx  = idx_q;
  assign data_out     = sw_s2_q;

endmodule

// File: tb/tb_operand_entry_ctrl.sv
// Self-checking bench for operand_entry_ctrl (DEBOUNCE=4, COMPUTE=5).
// Vector table for sync/debounce timing plus directed multi-cycle sequences.
module tb_operand_entry_ctrl;

  localparam int D = 4;
  localparam int C = 5;

  logic       clk = 1'b0;
  logic       resetn;
  logic       key_n;
  logic [7:0] sw;
  logic       go;
  logic [7:0] data_out;
  logic [1:0] operand_idx;
  logic       busy;
  logic       result_valid;

  int checks   = 0;
  int failures = 0;

  operand_entry_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .COMPUTE_CYCLES (C)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .key_n       (key_n),
    .sw          (sw),
    .go          (go),
    .data_out    (data_out),
    .operand_idx (operand_idx),
    .busy        (busy),
    .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // evaluator stand-in: latch data_out at each go rise
  logic [7:0] ops [4];
  logic       go_prev   = 1'b0;
  int         go_rises  = 0;
  int         rv_pulses = 0;
  int         overlap   = 0;

  always @(negedge clk) begin
    if (go && !go_prev) begin
      ops[operand_idx] = data_out;
      go_rises++;
    end
    if (result_valid) rv_pulses++;
    if (result_valid && busy) overlap++;
    go_prev = go;
  end

  typedef struct {
    logic       key_n;
    logic [7:0] sw;
    int         n;
    logic       go;
    logic [1:0] idx;
    logic       busy;
    logic       rv;
    logic [7:0] dat;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic k, input logic [7:0] s, input int n,
                     input logic g, input logic [1:0] i,
                     input logic [7:0] d);
    vec_t v;
    v.key_n = k;
    v.sw    = s;
    v.n     = n;
    v.go    = g;
    v.idx   = i;
    v.busy  = 1'b0;
    v.rv    = 1'b0;
    v.dat   = d;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string name);
    chk(name, {19'd0, go, operand_idx, busy, result_valid, data_out},
        32'd0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    key_n  = 1'b1;
    #3;
    chk_zero("reset_async");
    tick_n(2);
    chk_zero("reset_hold");
    resetn = 1'b1;
    tick();
  endtask

  task automatic press_release(input logic [7:0] v,
                               input logic [1:0] ei);
    logic [1:0] nx;
    nx = (ei == 2'd3) ? 2'd0 : ei + 2'd1;
    sw = v;
    tick_n(3);
    key_n = 1'b0;
    tick_n(D + 2);
    chk("go_early", {31'd0, go}, 32'd0);
    tick();
    chk("go_rise", {29'd0, go, operand_idx}, {29'd0, 1'b1, ei});
    tick_n(4);
    key_n = 1'b1;
    tick_n(D + 2);
    chk("go_hold", {31'd0, go}, 32'd1);
    tick();
    chk("go_fall", {29'd0, go, operand_idx}, {29'd0, 1'b0, nx});
    chk("op_capture", {24'd0, ops[ei]}, {24'd0, v});
  endtask

  initial begin
    int n;
    int rises0;
    logic [7:0] res;

    key_n  = 1'b1;
    sw     = 8'h00;
    resetn = 1'b0;
    do_reset();

    // sw synchronizer latency
    add(1'b1, 8'h5A, 1, 1'b0, 2'd0, 8'h00);
    add(1'b1, 8'h5A, 1, 1'b0, 2'd0, 8'h5A);
    // bounces of 3 cycles must never move go
    for (int i = 0; i < 5; i++) begin
      add(1'b0, 8'h5A, 3, 1'b0, 2'd0, 8'h5A);
      add(1'b1, 8'h5A, 3, 1'b0, 2'd0, 8'h5A);
    end
    add(1'b1, 8'h5A, 6, 1'b0, 2'd0, 8'h5A);
    // clean press: go at edge 7, release 20 later, fall 7 after
    add(1'b0, 8'h5A, 6, 1'b0, 2'd0, 8'h5A);
    add(1'b0, 8'h5A, 1, 1'b1, 2'd0, 8'h5A);
    add(1'b0, 8'h5A, 13, 1'b1, 2'd0, 8'h5A);
    add(1'b1, 8'h5A, 6, 1'b1, 2'd0, 8'h5A);
    add(1'b1, 8'h5A, 1, 1'b0, 2'd1, 8'h5A);

    foreach (vecs[i]) begin
      key_n = vecs[i].key_n;
      sw    = vecs[i].sw;
      tick_n(vecs[i].n);
      chk($sformatf("vec%0d", i),
          {19'd0, go, operand_idx, busy, result_valid, data_out},
          {19'd0, vecs[i].go, vecs[i].idx, vecs[i].busy,
           vecs[i].rv, vecs[i].dat});
    end

    // full entry and evaluation: 2*2*2 + 3*2 + 1
    do_reset();
    press_release(8'h02, 2'd0);
    press_release(8'h03, 2'd1);
    press_release(8'h01, 2'd2);
    press_release(8'h02, 2'd3);
    n = 0;
    while (busy && n < 20) begin
      n++;
      tick();
    end
    chk("busy_cycles", n, C + 1);
    chk("done_rv", {30'd0, result_valid, busy}, 32'd2);
    tick();
    chk("rv_one_cycle", {31'd0, result_valid}, 32'd0);
    res = ops[0] * ops[3] * ops[3] + ops[1] * ops[3] + ops[2];
    chk("eval_result", {24'd0, res}, 32'h0F);

    // key held through COMPUTE into DONE -> REARM, no go
    press_release(8'h02, 2'd0);
    press_release(8'h03, 2'd1);
    press_release(8'h01, 2'd2);
    sw = 8'h02;
    tick_n(3);
    key_n = 1'b0;
    tick_n(D + 3);
    chk("x_go_rise", {31'd0, go}, 32'd1);
    tick_n(4);
    key_n = 1'b1;
    tick_n(D + 3);
    chk("x_go_fall", {30'd0, go, busy}, 32'd1);
    key_n = 1'b0;
    rises0 = go_rises;
    tick_n(25);
    chk("rearm_no_go", go_rises - rises0, 0);
    chk("rearm_go_low", {31'd0, go}, 32'd0);
    key_n = 1'b1;
    tick_n(D + 6);
    chk("rearm_release", {31'd0, go}, 32'd0);
    key_n = 1'b0;
    tick_n(D + 2);
    chk("rearm_go_early", {31'd0, go}, 32'd0);
    tick();
    chk("rearm_go_rise", {29'd0, go, operand_idx}, {29'd0, 3'b100});
    key_n = 1'b1;
    tick_n(D + 3);
    chk("rearm_go_fall", {29'd0, go, operand_idx}, 32'd1);

    // reset in the middle of COMPUTE
    do_reset();
    press_release(8'hFF, 2'd0);
    press_release(8'hFF, 2'd1);
    press_release(8'hFF, 2'd2);
    press_release(8'hFF, 2'd3);
    tick_n(2);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    resetn = 1'b0;
    #2;
    chk_zero("mid_reset_zero");
    #4;
    resetn = 1'b1;
    tick();
    press_release(8'h07, 2'd0);
    tick_n(10);

    chk("rv_pulses", rv_pulses, 2);
    chk("busy_rv_overlap", overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
